// File: rtl/riscv_pkg.sv
// Shared RV32I constants used by the execute-stage branch logic.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational RV32I branch condition evaluator; illegal flags reserved funct3 codes.
module branch_cond_eval
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution stage: resolves direction and target, flags
// mispredicts for fetch, and keeps saturating branch/mispredict statistics.
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int CNT_W        = 16,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_branch,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_redirect,
  output logic [XLEN-1:0]  out_redirect_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            cond_taken, cond_illegal;
  logic            accept, fire;
  logic [XLEN-1:0] pc_imm, rs1_imm, link;
  logic            res_taken, res_redirect, res_illegal, res_ctrl;
  logic [XLEN-1:0] res_target, res_redirect_pc;

  logic             valid_d, valid_q;
  logic             taken_d, taken_q;
  logic [XLEN-1:0]  target_d, target_q;
  logic [XLEN-1:0]  link_d, link_q;
  logic             redirect_d, redirect_q;
  logic [XLEN-1:0]  redirect_pc_d, redirect_pc_q;
  logic             illegal_d, illegal_q;
  logic             ctrl_d, ctrl_q;
  logic [CNT_W-1:0] branch_cnt_d, branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3  (in_funct3),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign fire     = valid_q && out_ready;

  // Resolve the incoming request; jalr > jal > branch when several flags are set.
  always_comb begin
    pc_imm       = in_pc + in_imm;
    rs1_imm      = in_rs1 + in_imm;
    link         = in_pc + XLEN'(4);
    res_taken    = 1'b0;
    res_target   = pc_imm;
    res_redirect = 1'b0;
    res_illegal  = 1'b0;
    res_ctrl     = 1'b0;
    if (in_is_jalr) begin
      res_taken    = 1'b1;
      res_target   = {rs1_imm[XLEN-1:1], 1'b0};
      res_redirect = 1'b1;
      res_ctrl     = 1'b1;
    end else if (in_is_jal) begin
      res_taken    = 1'b1;
      res_redirect = !in_pred_taken;
      res_ctrl     = 1'b1;
    end else if (in_is_branch) begin
      res_taken    = cond_taken;
      res_illegal  = cond_illegal && ILLEGAL_TRAP;
      res_redirect = (cond_taken != in_pred_taken);
      res_ctrl     = 1'b1;
    end
    res_redirect_pc = res_taken ? res_target : link;
  end

  // Output register and counters; flush beats accept, but a same-cycle fire still counts.
  always_comb begin
    valid_d       = valid_q;
    taken_d       = taken_q;
    target_d      = target_q;
    link_d        = link_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = illegal_q;
    ctrl_d        = ctrl_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (flush)       valid_d = 1'b0;
    else if (accept) valid_d = 1'b1;
    else if (fire)   valid_d = 1'b0;

    if (accept) begin
      taken_d       = res_taken;
      target_d      = res_target;
      link_d        = link;
      redirect_d    = res_redirect;
      redirect_pc_d = res_redirect_pc;
      illegal_d     = res_illegal;
      ctrl_d        = res_ctrl;
    end

    if (fire && ctrl_q && branch_cnt_q != CNT_MAX)
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    if (fire && redirect_q && mispred_cnt_q != CNT_MAX)
      mispred_cnt_d = mispred_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      target_q      <= '0;
      link_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
      ctrl_q        <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      taken_q       <= taken_d;
      target_q      <= target_d;
      link_q        <= link_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
      ctrl_q        <= ctrl_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_taken        = taken_q;
  assign out_target       = target_q;
  assign out_link         = link_q;
  assign out_redirect     = redirect_q;
  assign out_redirect_pc  = redirect_pc_q;
  assign out_illegal      = illegal_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a second CNT_W=2 instance shares the
// stimulus so counter saturation can be observed.
module tb_branch_resolve_unit;

  logic        clk, rst_n;
  logic        in_valid, in_is_branch, in_is_jal, in_is_jalr, in_pred_taken;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
  logic        flush, out_ready;

  logic        in_ready, out_valid, out_taken, out_redirect, out_illegal;
  logic [31:0] out_target, out_link, out_redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  logic        b_in_ready, b_out_valid, b_out_taken, b_out_redirect, b_out_illegal;
  logic [31:0] b_out_target, b_out_link, b_out_redirect_pc;
  logic [1:0]  b_branch_count, b_mispredict_count;

  int n_vec = 0;
  int n_miss = 0;
  int exp_bc = 0;
  int exp_mc = 0;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_imm(in_imm), .in_pred_taken(in_pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(2), .ILLEGAL_TRAP(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_imm(in_imm), .in_pred_taken(in_pred_taken), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_taken(b_out_taken),
    .out_target(b_out_target), .out_link(b_out_link), .out_redirect(b_out_redirect),
    .out_redirect_pc(b_out_redirect_pc), .out_illegal(b_out_illegal),
    .branch_count(b_branch_count), .mispredict_count(b_mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    in_valid      = 1'b1;
    in_is_branch  = br;
    in_is_jal     = jal;
    in_is_jalr    = jalr;
    in_funct3     = f3;
    in_rs1        = rs1;
    in_rs2        = rs2;
    in_pc         = pc;
    in_imm        = imm;
    in_pred_taken = pred;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_is_branch = 1'b0;
    in_is_jal    = 1'b0;
    in_is_jalr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle();
    in_funct3 = 3'b000; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;
    #12;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_valid got %0h exp 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_in_ready got %0h exp 1", in_ready); end
    n_vec++; if (out_redirect_pc !== 32'h0) begin n_miss++; $display("[TB] FAIL reset_rpc got %0h exp 0", out_redirect_pc); end
    n_vec++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin n_miss++; $display("[TB] FAIL reset_cnt got %0d/%0d exp 0/0", branch_count, mispredict_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    step();
    idle();
    n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("[TB] FAIL beq_valid got %0h exp 1", out_valid); end
    n_vec++; if (out_taken !== 1'b1) begin n_miss++; $display("[TB] FAIL beq_taken got %0h exp 1", out_taken); end
    n_vec++; if (out_redirect !== 1'b1) begin n_miss++; $display("[TB] FAIL beq_redirect got %0h exp 1", out_redirect); end
    n_vec++; if (out_redirect_pc !== 32'h120) begin n_miss++; $display("[TB] FAIL beq_rpc got %0h exp 120", out_redirect_pc); end
    n_vec++; if (out_link !== 32'h104) begin n_miss++; $display("[TB] FAIL beq_link got %0h exp 104", out_link); end
    step();
    exp_bc += 1; exp_mc += 1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL beq_drain got %0h exp 0", out_valid); end
    n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL beq_cnt got %0d/%0d exp %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
  endtask

  task automatic test_signed_unsigned();
    logic [2:0] f3s [4]  = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic       exp_t [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       preds [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, f3s[i], 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, preds[i]);
      step();
      n_vec++; if (out_taken !== exp_t[i]) begin n_miss++; $display("[TB] FAIL cmp%0d_taken got %0h exp %0h", i, out_taken, exp_t[i]); end
      n_vec++; if (out_redirect !== (exp_t[i] ^ preds[i])) begin n_miss++; $display("[TB] FAIL cmp%0d_redirect got %0h exp %0h", i, out_redirect, exp_t[i] ^ preds[i]); end
      n_vec++; if (out_redirect_pc !== (exp_t[i] ? 32'h240 : 32'h204)) begin n_miss++; $display("[TB] FAIL cmp%0d_rpc got %0h", i, out_redirect_pc); end
    end
    idle();
    step();
    exp_bc += 4; exp_mc += 2;
    n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL cmp_cnt got %0d/%0d exp %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
  endtask

  task automatic test_jumps();
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h1003, 32'h0, 32'h300, 32'h4, 1'b1);
    step();
    n_vec++; if (out_target !== 32'h1006) begin n_miss++; $display("[TB] FAIL jalr_target got %0h exp 1006", out_target); end
    n_vec++; if (out_link !== 32'h304) begin n_miss++; $display("[TB] FAIL jalr_link got %0h exp 304", out_link); end
    n_vec++; if (out_taken !== 1'b1 || out_redirect !== 1'b1) begin n_miss++; $display("[TB] FAIL jalr_flags got %0h/%0h exp 1/1", out_taken, out_redirect); end
    n_vec++; if (out_illegal !== 1'b0) begin n_miss++; $display("[TB] FAIL jalr_illegal got %0h exp 0", out_illegal); end
    drive(1'b0, 1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h400, 32'hFFFF_FFF8, 1'b1);
    step();
    n_vec++; if (out_target !== 32'h3F8 || out_redirect !== 1'b0) begin n_miss++; $display("[TB] FAIL jal got %0h/%0h exp 3f8/0", out_target, out_redirect); end
    drive(1'b1, 1'b1, 1'b1, 3'b001, 32'h2000, 32'h2000, 32'h500, 32'h10, 1'b1);
    step();
    n_vec++; if (out_target !== 32'h2010 || out_redirect !== 1'b1) begin n_miss++; $display("[TB] FAIL prio got %0h/%0h exp 2010/1", out_target, out_redirect); end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h7, 32'h7, 32'h600, 32'h10, 1'b1);
    step();
    n_vec++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_redirect !== 1'b0) begin n_miss++; $display("[TB] FAIL noctl got v%0h t%0h r%0h exp 1/0/0", out_valid, out_taken, out_redirect); end
    idle();
    step();
    exp_bc += 3; exp_mc += 2;
    n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL jump_cnt got %0d/%0d exp %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd1, 32'd2, 32'h500, 32'h10, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd3, 32'd3, 32'h600, 32'h8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_miss++; $display("[TB] FAIL bp%0d_hs got rdy%0h v%0h exp 0/1", i, in_ready, out_valid); end
      n_vec++; if (out_target !== 32'h510 || out_redirect !== 1'b1) begin n_miss++; $display("[TB] FAIL bp%0d_hold got %0h/%0h exp 510/1", i, out_target, out_redirect); end
      n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL bp%0d_cnt got %0d/%0d exp %0d/%0d", i, branch_count, mispredict_count, exp_bc, exp_mc); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_release got %0h exp 1", in_ready); end
    step();
    idle();
    exp_bc += 1; exp_mc += 1;
    n_vec++; if (out_valid !== 1'b1 || out_target !== 32'h608 || out_redirect !== 1'b0) begin n_miss++; $display("[TB] FAIL bp_next got v%0h %0h r%0h exp 1/608/0", out_valid, out_target, out_redirect); end
    n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL bp_fire_cnt got %0d/%0d exp %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    step();
    exp_bc += 1;
    n_vec++; if (out_valid !== 1'b0 || branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL bp_drain got v%0h %0d/%0d exp 0 %0d/%0d", out_valid, branch_count, mispredict_count, exp_bc, exp_mc); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd7, 32'h700, 32'h10, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd1, 32'd2, 32'h800, 32'h20, 1'b0);
    flush = 1'b1;
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_valid got %0h exp 0", out_valid); end
    n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL flush_cnt got %0d/%0d exp %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    flush = 1'b0;
    idle();
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_drop got %0h exp 0", out_valid); end
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd7, 32'h700, 32'h10, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd1, 32'd2, 32'h800, 32'h20, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    exp_bc += 1; exp_mc += 1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL flushfire_valid got %0h exp 0", out_valid); end
    n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL flushfire_cnt got %0d/%0d exp %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    step();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'd9, 32'd9, 32'h800, 32'h40, 1'b1);
    step();
    n_vec++; if (out_illegal !== 1'b1 || out_taken !== 1'b0) begin n_miss++; $display("[TB] FAIL ill010 got i%0h t%0h exp 1/0", out_illegal, out_taken); end
    n_vec++; if (out_redirect !== 1'b1 || out_redirect_pc !== 32'h804) begin n_miss++; $display("[TB] FAIL ill010_redir got %0h/%0h exp 1/804", out_redirect, out_redirect_pc); end
    drive(1'b1, 1'b0, 1'b0, 3'b011, 32'd1, 32'd9, 32'h900, 32'h40, 1'b0);
    step();
    n_vec++; if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_redirect !== 1'b0) begin n_miss++; $display("[TB] FAIL ill011 got i%0h t%0h r%0h exp 1/0/0", out_illegal, out_taken, out_redirect); end
    idle();
    step();
    exp_bc += 2; exp_mc += 1;
    n_vec++; if (branch_count !== 16'(exp_bc) || mispredict_count !== 16'(exp_mc)) begin n_miss++; $display("[TB] FAIL ill_cnt got %0d/%0d exp %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
  endtask

  task automatic test_reset_and_saturate();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1, 32'hA00, 32'h4, 1'b0);
    step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL arst_valid got %0h/%0h exp 0/0", out_valid, b_out_valid); end
    n_vec++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0 || b_branch_count !== 2'd0) begin n_miss++; $display("[TB] FAIL arst_cnt got %0d/%0d/%0d exp 0", branch_count, mispredict_count, b_branch_count); end
    #1 rst_n = 1'b1;
    exp_bc = 0; exp_mc = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1, 32'hB00, 32'h8, 1'b0);
      step();
    end
    idle();
    step();
    n_vec++; if (branch_count !== 16'd5 || mispredict_count !== 16'd5) begin n_miss++; $display("[TB] FAIL sat_wide got %0d/%0d exp 5/5", branch_count, mispredict_count); end
    n_vec++; if (b_branch_count !== 2'd3 || b_mispredict_count !== 2'd3) begin n_miss++; $display("[TB] FAIL sat_narrow got %0d/%0d exp 3/3", b_branch_count, b_mispredict_count); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_jumps();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_and_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
